// File: rtl/stepper_step_driver.sv
// One STEP/DIR/ENABLE channel: a fixed-width step pulse per FM_in rising edge, automatic
// reversal every TRAVEL_STEPS steps, and velocity-gated enable with wake delay and idle power-down.
module stepper_step_driver #(
  parameter int PULSE_CYCLES = 100,
  parameter int DIR_SETUP    = 50,
  parameter int WAKE_CYCLES  = 50000,
  parameter int IDLE_TIMEOUT = 50000000,
  parameter int TRAVEL_STEPS = 400,
  parameter int CNT_W        = 26
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       FM_in,
  input  logic [7:0] VelIn,
  output logic       Step,
  output logic       Dir,
  output logic       En_n,
  output logic       Overrun,
  output logic       Active
);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_WAKE,
    S_IDLE,
    S_PULSE,
    S_DIR_SETUP
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] IDLE_LIM   = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] TRAVEL     = CNT_W'(TRAVEL_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             fm_q;
  logic             pending, pending_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_nxt;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  logic             dir_nxt, overrun_nxt;
  logic             vel_on, valid_edge, timeout;

  assign vel_on     = |VelIn;
  assign valid_edge = FM_in & ~fm_q & vel_on;
  assign timeout    = (idle_cnt == IDLE_LIM);

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    pending_nxt  = pending;
    step_cnt_nxt = step_cnt;
    dir_nxt      = Dir;
    overrun_nxt  = 1'b0;
    idle_nxt     = vel_on ? '0 : (timeout ? idle_cnt : idle_cnt + CNT_ONE);

    // One-deep request queue while the output is busy
    if (valid_edge && (state == S_PULSE || state == S_DIR_SETUP)) begin
      if (pending) overrun_nxt = 1'b1;
      else         pending_nxt = 1'b1;
    end

    case (state)
      S_DISABLED: begin
        if (vel_on) begin
          state_nxt = S_WAKE;
          timer_nxt = '0;
        end
      end
      S_WAKE: begin
        if (timeout) begin
          state_nxt   = S_DISABLED;
          pending_nxt = 1'b0;
        end else if (timer == WAKE_LAST) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end
      S_IDLE: begin
        if (timeout) begin
          state_nxt   = S_DISABLED;
          pending_nxt = 1'b0;
        end else if (valid_edge || pending) begin
          // A fresh edge arriving while a queued one is serviced stays queued
          state_nxt    = S_PULSE;
          timer_nxt    = '0;
          pending_nxt  = pending & valid_edge;
          step_cnt_nxt = step_cnt + CNT_ONE;
        end
      end
      S_PULSE: begin
        if (timer == PULSE_LAST) begin
          timer_nxt = '0;
          if (step_cnt == TRAVEL) begin
            step_cnt_nxt = '0;
            dir_nxt      = ~Dir;
            state_nxt    = S_DIR_SETUP;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end
      S_DIR_SETUP: begin
        if (timer == SETUP_LAST) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_DISABLED;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= S_DISABLED;
      fm_q     <= 1'b0;
      pending  <= 1'b0;
      timer    <= '0;
      idle_cnt <= '0;
      step_cnt <= '0;
      Step     <= 1'b0;
      Dir      <= 1'b0;
      En_n     <= 1'b1;
      Overrun  <= 1'b0;
      Active   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fm_q     <= FM_in;
      pending  <= pending_nxt;
      timer    <= timer_nxt;
      idle_cnt <= idle_nxt;
      step_cnt <= step_cnt_nxt;
      Step     <= (state_nxt == S_PULSE);
      Dir      <= dir_nxt;
      En_n     <= (state_nxt == S_DISABLED);
      Overrun  <= overrun_nxt;
      Active   <= (state_nxt != S_DISABLED);
    end
  end

endmodule

// File: tb/tb_stepper_step_driver.sv
// Bench for stepper_step_driver: directed scenarios plus random FM/velocity traffic,
// every output compared each clock against a countdown-style behavioural model.
module tb_stepper_step_driver;

  localparam int P  = 4;
  localparam int D  = 5;
  localparam int W  = 10;
  localparam int T  = 30;
  localparam int TR = 3;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       FM_in;
  logic [7:0] VelIn;
  logic       Step, Dir, En_n, Overrun, Active;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  int m_en, m_wake, m_pulse, m_setup, m_q, m_steps, m_dir, m_idle, m_ovr, m_fm_prev;

  stepper_step_driver #(
    .PULSE_CYCLES(P), .DIR_SETUP(D), .WAKE_CYCLES(W),
    .IDLE_TIMEOUT(T), .TRAVEL_STEPS(TR), .CNT_W(26)
  ) dut (
    .Clk(Clk), .Rst(Rst), .FM_in(FM_in), .VelIn(VelIn),
    .Step(Step), .Dir(Dir), .En_n(En_n), .Overrun(Overrun), .Active(Active)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_wake = 0; m_pulse = 0; m_setup = 0; m_q = 0;
    m_steps = 0; m_dir = 0; m_idle = 0; m_ovr = 0; m_fm_prev = 0;
  endtask

  // Advance the model by one posedge using the currently driven inputs
  task automatic model_step();
    int valid, timeout;
    valid   = (FM_in && !m_fm_prev && VelIn != 0) ? 1 : 0;
    timeout = (m_idle == T) ? 1 : 0;
    m_fm_prev = FM_in;
    m_idle = (VelIn != 0) ? 0 : ((m_idle < T) ? m_idle + 1 : T);
    m_ovr = 0;
    if (!m_en) begin
      if (VelIn != 0) begin m_en = 1; m_wake = W; end
    end else if (m_wake > 0) begin
      if (timeout) begin m_en = 0; m_q = 0; m_wake = 0; end
      else m_wake--;
    end else if (m_pulse > 0 || m_setup > 0) begin
      if (valid) begin
        if (m_q) m_ovr = 1;
        else m_q = 1;
      end
      if (m_pulse > 0) begin
        m_pulse--;
        if (m_pulse == 0 && m_steps == TR) begin
          m_steps = 0; m_dir ^= 1; m_setup = D;
        end
      end else begin
        m_setup--;
      end
    end else begin
      if (timeout) begin m_en = 0; m_q = 0; end
      else if (valid || m_q) begin
        m_q = (m_q && valid) ? 1 : 0;
        m_pulse = P;
        m_steps++;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("step",    32'(Step),    32'(m_pulse > 0));
    check_val("dir",     32'(Dir),     32'(m_dir));
    check_val("en_n",    32'(En_n),    32'(!m_en));
    check_val("overrun", 32'(Overrun), 32'(m_ovr));
    check_val("active",  32'(Active),  32'(m_en));
  endtask

  task automatic cycle(input logic fm, input logic [7:0] vel);
    FM_in = fm;
    VelIn = vel;
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    check_outputs();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear with no clock
  task automatic async_reset(input string tag);
    #2 Rst = 1'b1;
    #1;
    check_val({tag, "_step"},    32'(Step),    0);
    check_val({tag, "_dir"},     32'(Dir),     0);
    check_val({tag, "_en_n"},    32'(En_n),    1);
    check_val({tag, "_overrun"}, 32'(Overrun), 0);
    check_val({tag, "_active"},  32'(Active),  0);
    #1 Rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int found;
    int blk_len;
    logic [7:0] vel;
    logic fm;

    Rst = 1'b1; FM_in = 1'b0; VelIn = 8'd0;
    model_reset();
    #2;
    check_val("reset_step",    32'(Step),    0);
    check_val("reset_dir",     32'(Dir),     0);
    check_val("reset_en_n",    32'(En_n),    1);
    check_val("reset_overrun", 32'(Overrun), 0);
    check_val("reset_active",  32'(Active),  0);
    @(negedge Clk);
    Rst = 1'b0;

    // basic stepping and reversals: FM toggles every 20 clocks
    for (int i = 0; i < 260; i++) cycle(((i / 20) % 2) == 1, 8'd64);

    // edges two clocks apart: queueing and overrun
    for (int i = 0; i < 6; i++) cycle(i % 2 == 1, 8'd64);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'd64);
    for (int i = 0; i < 40; i++) cycle(i % 2 == 1, 8'd64);

    // velocity zero below timeout with edges, then resume
    for (int i = 0; i < 10; i++) cycle(i % 2 == 1, 8'd0);
    for (int i = 0; i < 60; i++) cycle(((i / 5) % 2) == 1, 8'd64);

    // idle timeout with velocity dropped mid-pulse, then re-wake
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'd64);
    cycle(1'b1, 8'd64);
    cycle(1'b1, 8'd64);
    for (int i = 0; i < 70; i++) cycle(((i / 3) % 2) == 1, 8'd0);
    for (int i = 0; i < 80; i++) cycle(((i / 5) % 2) == 1, 8'd200);

    // reset during a pulse
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle(((i / 6) % 2) == 1, 8'd64);
      if (m_pulse > 0 && m_pulse < P) found = 1;
    end
    check_val("pulse_reached", 32'(found), 1);
    if (found) async_reset("rst_pulse");
    for (int i = 0; i < 60; i++) cycle(((i / 6) % 2) == 1, 8'd64);

    // reset during direction setup
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle(((i / 6) % 2) == 1, 8'd64);
      if (m_setup > 0) found = 1;
    end
    check_val("setup_reached", 32'(found), 1);
    if (found) async_reset("rst_setup");
    for (int i = 0; i < 60; i++) cycle(((i / 6) % 2) == 1, 8'd64);

    // random traffic in blocks of random velocity, including zero stretches
    fm = 1'b0;
    for (int b = 0; b < 80; b++) begin
      blk_len = $urandom_range(5, 60);
      vel = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      for (int i = 0; i < blk_len; i++) begin
        if ($urandom_range(0, 3) == 0) fm = ~fm;
        cycle(fm, vel);
      end
      if ($urandom_range(0, 39) == 0) async_reset("rst_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stepper_step_driver.md
Name: stepper_step_driver

Overview:
- Downstream stage of the stepper frequency modulator. Consumes its square wave (FM_in) and pass-through velocity (VelIn).
- Drives one STEP/DIR/ENABLE stepper driver channel (A4988-class):
  - One fixed-width step pulse per FM_in rising edge.
  - Reverses direction automatically after TRAVEL_STEPS steps, so the motor dithers in place.
  - Gates driver enable from velocity, with a wake delay and an idle-timeout power-down.
- One instance per stepper channel.

Parameters:
- PULSE_CYCLES, 100: STEP high time in clocks (2 us at 50 MHz); minimum 1.
- DIR_SETUP, 50: clocks Dir must be stable before the next step after a reversal; minimum 1.
- WAKE_CYCLES, 50000: clocks from En_n falling to first accepted step (1 ms).
- IDLE_TIMEOUT, 50000000: consecutive VelIn==0 clocks before driver disable (1 s); must be greater than PULSE_CYCLES + DIR_SETUP.
- TRAVEL_STEPS, 400: steps per direction before reversal; minimum 1.
- CNT_W, 26: width of the internal timers; must hold every cycle parameter.

Ports:
- Clk  in  1  50 MHz system clock; all logic on posedge.
- Rst  in  1  asynchronous, active-high reset.
- FM_in  in  1  square wave from the modulator, same clock domain.
- VelIn  in  8  note velocity; 0 = note off.
- Step  out  1  STEP pulse to the driver.
- Dir  out  1  direction to the driver.
- En_n  out  1  driver enable, active-low.
- Overrun  out  1  one-clock strobe: a step request was dropped.
- Active  out  1  high when state is not DISABLED.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: Step=0, Dir=0, En_n=1, Overrun=0, Active=0.
  - Internal: state=DISABLED, fm_q=0, step_cnt=0, pending=0, all timers 0.
- Edge detect: fm_q registers FM_in. An edge exists at a posedge when FM_in=1 and fm_q=0. An edge is valid only when VelIn!=0 at that posedge.
- All outputs are registered. The state encoding is free.
- DISABLED:
  - En_n=1, Step=0.
  - Edges are ignored; Overrun is not raised.
  - VelIn!=0 -> WAKE, clear timer.
- WAKE:
  - En_n=0.
  - Timer counts to WAKE_CYCLES, then -> IDLE.
  - Edges during WAKE are dropped silently.
  - If VelIn returns to 0 during WAKE, the idle counter runs as in IDLE.
- IDLE:
  - A valid edge or pending=1 -> PULSE.
  - Step=1 from the same posedge. Clear pending. step_cnt += 1.
- PULSE:
  - Step held high for exactly PULSE_CYCLES clocks, then Step=0.
  - If step_cnt==TRAVEL_STEPS: step_cnt=0, toggle Dir on the same posedge Step falls, -> DIR_SETUP.
  - Otherwise -> IDLE.
- DIR_SETUP:
  - Step=0 for DIR_SETUP clocks, then -> IDLE.
- Valid edge in PULSE or DIR_SETUP:
  - If pending=0: set pending=1.
  - If pending=1: the request is dropped and Overrun=1 for one clock.
  - One-deep queue only.
- Pending service: pending is consumed on IDLE entry. The next Step rises one clock after the previous pulse or setup period ends.
- Minimum step spacing is therefore PULSE_CYCLES+1 clocks low-to-high.
- Idle counter:
  - Increments each clock VelIn==0, saturating at IDLE_TIMEOUT.
  - Cleared whenever VelIn!=0.
- Disable on timeout: when idle count == IDLE_TIMEOUT and state is IDLE or WAKE -> DISABLED, En_n=1, pending=0.
  - In PULSE or DIR_SETUP, disable waits for the return to IDLE; the current pulse is never truncated.
- Dir and step_cnt are retained across DISABLED; only Rst clears them.
- Simultaneous events:
  - Edge and timeout on the same posedge: edge is invalid (VelIn==0), so disable wins.
  - Valid edge on the posedge PULSE ends: the edge sets pending and is serviced on the next posedge.
- Reset mid-pulse: Step drops immediately (asynchronous).

Test Plan:
- Basic stepping:
  - Stimulus: PULSE_CYCLES=4, WAKE_CYCLES=10; VelIn=64; FM_in toggles every 20 clocks.
  - Response: En_n falls 1 clk after VelIn; no Step for 10 clks; then each FM_in rise gives Step high exactly 4 clks, starting the posedge after the rise.
- Reversal:
  - Stimulus: TRAVEL_STEPS=3, DIR_SETUP=5.
  - Response: Dir toggles on the falling edge of the 3rd Step; no Step for the following 5 clks; 6th step completes with Dir back to 0.
- Pending and overrun:
  - Stimulus: FM_in edges 2 clks apart with PULSE_CYCLES=4.
  - Response: 2nd edge queued, its Step rises 1 clk after the first falls; 3rd edge within the same pulse gives Overrun=1 for exactly 1 clk.
- Idle timeout:
  - Stimulus: IDLE_TIMEOUT=30; VelIn->0 mid-pulse.
  - Response: pulse completes at full width; En_n rises 30 clks after VelIn==0; later FM_in edges produce no Step; Dir and step_cnt are preserved on re-wake.
- Reset mid-operation:
  - Stimulus: assert Rst during PULSE and during DIR_SETUP.
  - Response: Step=0, En_n=1, Dir=0 immediately, with no clock required; after release, the first Step needs a full WAKE.
- Velocity zero while enabled:
  - Stimulus: VelIn=0 for 10 clks (below timeout) with FM_in edges.
  - Response: no Step, no Overrun, En_n stays 0; stepping resumes at the next edge after VelIn!=0.
